// File: rtl/popcount_window.sv
// Two-stage valid/ready pipeline that reports the popcount of each accepted vector,
// flags whether it falls inside [LO, HI], and counts delivered hits with saturation.
module popcount_window #(
    parameter int WIDTH = 4,
    parameter int LO    = 2,
    parameter int HI    = 3,
    parameter int CNT_W = 16,
    localparam int CW   = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             o,
    output logic [CW-1:0]    count,
    input  logic             clear,
    output logic [CNT_W-1:0] hit_cnt
);

    function automatic logic [CW-1:0] popcnt(input logic [WIDTH-1:0] v);
        logic [CW-1:0] s;
        // NOTE: blocking assignment is correct here; s is a local accumulator, not state.
        s = '0;
        for (int k = 0; k < WIDTH; k++) begin
            s = s + CW'(v[k]);
        end
        return s;
    endfunction

    logic             s1_valid;
    logic [WIDTH-1:0] s1_data;
    logic [CW-1:0]    s1_count;
    logic             s1_hit;
    logic             s2_ready;

    assign s1_count = popcnt(s1_data);
    assign s1_hit   = (s1_count >= CW'(LO)) && (s1_count <= CW'(HI));

    // S2 can take a new result when it is empty or its current result leaves this cycle.
    assign s2_ready = !out_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;

    // NOTE: all state below uses non-blocking assignments so every register samples
    // the pre-edge values of its neighbours, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            out_valid <= 1'b0;
            o         <= 1'b0;
            count     <= '0;
        end else begin
            if (in_valid && in_ready) begin
                s1_data  <= i;
                s1_valid <= 1'b1;
            end else if (s2_ready) begin
                s1_valid <= 1'b0;
            end

            // Zeroing o/count on an empty load keeps them at 0 whenever out_valid is 0.
            if (s2_ready) begin
                out_valid <= s1_valid;
                count     <= s1_valid ? s1_count : '0;
                o         <= s1_valid && s1_hit;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            hit_cnt <= '0;
        end else if (out_valid && out_ready && o && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_popcount_window.sv
// Scoreboard bench for popcount_window: drivers push hand-computed results,
// a negedge monitor pops them on every output transfer and models hit_cnt.
module tb_popcount_window;

    typedef struct {
        int cnt;
        bit o;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] i = 4'b0000;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic       clear = 1'b0;

    logic        in_ready, out_valid, o;
    logic [2:0]  count;
    logic [15:0] hit_cnt;

    logic        in_ready_2, out_valid_2, o_2;
    logic [2:0]  count_2;
    logic [1:0]  hit_cnt_2;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int exp_hit = 0;
    int exp_hit_2 = 0;
    exp_t exp_q[$];
    int xfer_cyc[$];

    popcount_window dut (
        .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .o(o), .count(count),
        .clear(clear), .hit_cnt(hit_cnt)
    );

    popcount_window #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .i(i), .in_valid(in_valid), .in_ready(in_ready_2),
        .out_valid(out_valid_2), .out_ready(out_ready), .o(o_2), .count(count_2),
        .clear(clear), .hit_cnt(hit_cnt_2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: scoreboard pops, zero-when-idle, hold-under-stall and hit counter model.
    bit prev_stall = 0;
    int prev_o = 0;
    int prev_count = 0;
    always @(negedge clk) begin
        bit hit;
        exp_t e;
        hit = 0;
        if (rst) begin
            exp_q.delete();
            exp_hit = 0;
            exp_hit_2 = 0;
            prev_stall = 0;
        end else begin
            check("hit_cnt", int'(hit_cnt), exp_hit);
            check("hit_cnt_sat", int'(hit_cnt_2), exp_hit_2);
            if (!out_valid) begin
                check("idle_o", int'(o), 0);
                check("idle_count", int'(count), 0);
            end
            if (prev_stall) begin
                check("held_valid", int'(out_valid), 1);
                check("held_o", int'(o), prev_o);
                check("held_count", int'(count), prev_count);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_count", int'(count), e.cnt);
                    check("out_o", int'(o), int'(e.o));
                    xfer_cyc.push_back(cyc);
                    hit = e.o;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_o = int'(o);
            prev_count = int'(count);
            if (clear) begin
                exp_hit = 0;
                exp_hit_2 = 0;
            end else if (hit) begin
                if (exp_hit < 65535) exp_hit++;
                if (exp_hit_2 < 3) exp_hit_2++;
            end
        end
    end

    task automatic send(input logic [3:0] v, input int ec, input bit eo);
        int n;
        bit done;
        exp_t e;
        n = 0;
        done = 0;
        i = v;
        in_valid = 1'b1;
        while (!done) begin
            @(negedge clk);
            if (in_ready) begin
                e.cnt = ec;
                e.o = eo;
                exp_q.push_back(e);
                acc_cyc = cyc;
                done = 1;
            end
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 50) begin
                check("send_timeout", 0, 1);
                done = 1;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [3:0] vtab[5] = '{4'b1000, 4'b1100, 4'b1110, 4'b1111, 4'b0101};
    int         ctab[5] = '{1, 2, 3, 4, 2};
    bit         otab[5] = '{0, 1, 1, 0, 1};
    int         sat_tab[5] = '{1, 2, 3, 3, 3};

    initial begin
        int acc;
        int n;

        // Reset state
        do_reset(2);
        @(negedge clk);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_o", int'(o), 0);
        check("rst_count", int'(count), 0);
        check("rst_hit_cnt", int'(hit_cnt), 0);
        check("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // Single hit vector, latency 2
        send(4'b0011, 2, 1);
        wait_drain();
        check("lat_cycles", xfer_cyc[$] - acc_cyc, 2);
        @(negedge clk);
        check("lat_hit_cnt", int'(hit_cnt), 1);
        @(posedge clk);
        #1;

        // Back-to-back results on consecutive cycles
        send(4'b1111, 4, 0);
        send(4'b0001, 1, 0);
        send(4'b0111, 3, 1);
        wait_drain();
        check("b2b_gap0", xfer_cyc[$-1] - xfer_cyc[$-2], 1);
        check("b2b_gap1", xfer_cyc[$] - xfer_cyc[$-1], 1);

        // Output stall with continuous input
        out_ready = 1'b0;
        acc = 0;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            i = vtab[acc];
            @(negedge clk);
            if (in_ready) begin
                exp_t e;
                e.cnt = ctab[acc];
                e.o = otab[acc];
                exp_q.push_back(e);
                acc++;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("stall_accepted", acc, 2);
        check("stall_in_ready", int'(in_ready), 0);
        check("stall_out_valid", int'(out_valid), 1);
        check("stall_held_count", int'(count), ctab[0]);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int k = 2; k < 5; k++) send(vtab[k], ctab[k], otab[k]);
        wait_drain();

        // Saturating counter (CNT_W=2)
        do_reset(1);
        for (int k = 0; k < 5; k++) begin
            send(4'b0011, 2, 1);
            wait_drain();
            @(negedge clk);
            check("sat_seq", int'(hit_cnt_2), sat_tab[k]);
            @(posedge clk);
            #1;
        end

        // Clear wins over a same-cycle hit transfer
        do_reset(1);
        for (int k = 0; k < 7; k++) send(4'b0110, 2, 1);
        wait_drain();
        @(negedge clk);
        check("pre_clear_hit_cnt", int'(hit_cnt), 7);
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        send(4'b1010, 2, 1);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        check("clear_setup_valid", int'(out_valid), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        clear = 1'b1;
        @(posedge clk);
        #1;
        clear = 1'b0;
        @(negedge clk);
        check("clear_hit_cnt", int'(hit_cnt), 0);
        check("clear_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;

        // Reset with both stages full
        do_reset(1);
        send(4'b1001, 2, 1);
        wait_drain();
        out_ready = 1'b0;
        send(4'b1011, 3, 1);
        send(4'b1101, 3, 1);
        @(negedge clk);
        check("full_in_ready", int'(in_ready), 0);
        check("full_hit_cnt", int'(hit_cnt), 1);
        @(posedge clk);
        #1;
        do_reset(1);
        @(negedge clk);
        check("post_rst_out_valid", int'(out_valid), 0);
        check("post_rst_hit_cnt", int'(hit_cnt), 0);
        check("post_rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("post_rst_no_stale", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/popcount_window.md
POPCOUNT_WINDOW -- requirements
Module: popcount_window

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, meaning input vector width (WIDTH >= 2).
REQ-002 The block SHALL have parameter LO, default 2, meaning lower bound of the hit window, inclusive.
REQ-003 The block SHALL have parameter HI, default 3, meaning upper bound of the hit window, inclusive, with LO <= HI <= WIDTH.
REQ-004 The block SHALL have parameter CNT_W, default 16, meaning hit counter width.
REQ-005 The block SHALL define CW = $clog2(WIDTH+1) as the popcount width.
REQ-006 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port rst, input, 1 bit, meaning synchronous active-high reset.
REQ-008 The block SHALL have port i, input, WIDTH bits, meaning the data vector.
REQ-009 The block SHALL have port in_valid, input, 1 bit, meaning i is valid.
REQ-010 The block SHALL have port in_ready, output, 1 bit, meaning the block accepts i this cycle.
REQ-011 The block SHALL have port out_valid, output, 1 bit, meaning the result is valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit, meaning the consumer accepts the result.
REQ-013 The block SHALL have port o, output, 1 bit, meaning LO <= popcount(i) <= HI for the presented result.
REQ-014 The block SHALL have port count, output, CW bits, meaning popcount of the presented result's vector.
REQ-015 The block SHALL have port clear, input, 1 bit, meaning synchronous clear of hit_cnt.
REQ-016 The block SHALL have port hit_cnt, output, CNT_W bits, meaning the saturating number of delivered results with o=1.

Function
REQ-017 The block SHALL complete an input transfer when in_valid && in_ready at a rising edge, and an output transfer when out_valid && out_ready at a rising edge.
REQ-018 The block SHALL implement a two-stage pipeline: S1 registers the accepted vector; S2 registers popcount, o and the valid flag of the S1 contents.
REQ-019 The block SHALL present the result of an accepted vector on o/count/out_valid exactly 2 cycles after acceptance when out_ready stays 1 (latency 2, throughput 1 per cycle).
REQ-020 The block SHALL load S2 from S1 when S2 is empty or being drained (!out_valid || out_ready).
REQ-021 The block SHALL drive in_ready = !s1_valid || (!out_valid || out_ready), combinationally and without dependence on in_valid.
REQ-022 The block SHALL hold o, count and out_valid stable while out_valid=1 and out_ready=0 (no drop, no duplicate, no reorder).
REQ-023 The block SHALL retain S1 when it is full and S2 is stalled; in that case in_ready=0.
REQ-024 The block SHALL compute count as the full-width sum of the bits of i, with no truncation (max WIDTH fits in CW).
REQ-025 The block SHALL drive o=0 and count=0 whenever out_valid=0.
REQ-026 The block SHALL increment hit_cnt by 1 on each output transfer with o=1, saturating at 2^CNT_W-1 (no wrap).
REQ-027 The block SHALL give clear priority over a same-cycle increment; hit_cnt becomes 0.
REQ-028 The block SHALL let clear affect only hit_cnt; pipeline contents and handshakes are unaffected.

Reset
REQ-029 The block SHALL, while rst=1 at a rising edge, empty S1 and S2 and set out_valid=0, o=0, count=0, hit_cnt=0.
REQ-030 The block SHALL drive in_ready=1 in the first cycle after reset deassertion.
REQ-031 The block SHALL discard in-flight data on reset mid-operation; no result from before reset appears afterward.
REQ-032 The block SHALL give rst priority over clear and all transfers.

Verification
REQ-033 The bench SHALL cover, with defaults and out_ready=1: i=4'b0011 accepted at cycle t -> out_valid=1, count=2, o=1 at t+2, and hit_cnt=1 after the transfer.
REQ-034 The bench SHALL cover back-to-back i=4'b1111, 4'b0001, 4'b0111 -> o=0,0,1 and count=4,1,3 on consecutive cycles.
REQ-035 The bench SHALL cover out_ready=0 for 5 cycles with continuous in_valid -> exactly 2 vectors accepted, then in_ready=0; the held outputs stay unchanged; after out_ready=1, results arrive in order with no loss.
REQ-036 The bench SHALL cover CNT_W=2 with 5 hit transfers -> hit_cnt sequence 1,2,3,3,3.
REQ-037 The bench SHALL cover clear=1 in the same cycle as a hit transfer with hit_cnt=7 -> hit_cnt=0 next cycle.
REQ-038 The bench SHALL cover rst=1 for 1 cycle with both stages full -> out_valid=0, hit_cnt=0 and in_ready=1 on the next cycle, with no stale result ever emitted.
